// File: rtl/modexp_job_dispatcher.sv
// Job dispatcher for a single modular_exp engine: buffers (m, e, n) jobs in a FIFO,
// launches them one at a time, screens n <= 1 and times out a silent engine.
module modexp_job_dispatcher #(
  parameter int BITS    = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BITS-1:0]          in_m,
  input  logic [BITS-1:0]          in_e,
  input  logic [BITS-1:0]          in_n,
  output logic                     exp_go,
  output logic [BITS-1:0]          exp_m,
  output logic [BITS-1:0]          exp_e,
  output logic [BITS-1:0]          exp_n,
  input  logic [BITS-1:0]          exp_r,
  input  logic                     exp_d,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BITS-1:0]          out_r,
  output logic                     out_err,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   FULL  = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, SCREEN, HOLD} state_t;

  state_t                state;
  logic [3*BITS-1:0]     mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         tcnt;
  logic                  n_zero;
  logic [BITS-1:0]       head_m;
  logic [BITS-1:0]       head_e;
  logic [BITS-1:0]       head_n;
  logic                  push;
  logic                  pop;

  assign in_ready = (count != FULL);
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && (count != '0) && !out_valid;
  assign {head_m, head_e, head_n} = mem[rd_ptr];

  // Storage is not reset; only pointers and occupancy define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_m, in_e, in_n};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      exp_go    <= 1'b0;
      exp_m     <= '0;
      exp_e     <= '0;
      exp_n     <= '0;
      out_valid <= 1'b0;
      out_r     <= '0;
      out_err   <= 1'b0;
      busy      <= 1'b0;
      tcnt      <= '0;
      n_zero    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            if (head_n <= BITS'(1)) begin
              n_zero <= (head_n == '0);
              state  <= SCREEN;
            end else begin
              // Operands, go and busy are registered here so they are live during LAUNCH.
              exp_m  <= head_m;
              exp_e  <= head_e;
              exp_n  <= head_n;
              exp_go <= 1'b1;
              busy   <= 1'b1;
              tcnt   <= '0;
              state  <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          exp_go <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          tcnt <= tcnt + 1'b1;
          if (exp_d) begin
            out_r     <= exp_r;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= HOLD;
          end else if (tcnt + 1'b1 == LIMIT) begin
            out_r     <= '0;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= HOLD;
          end
        end
        SCREEN: begin
          out_r     <= '0;
          out_err   <= n_zero;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
